millis_alarm: RTL and testbench

- Consumer of the free-running millisecond counter produced by millis_timer: compares the counter against a software-programmed deadline and raises a level interrupt.
- Supports one-shot and drift-free periodic operation, wrap-safe comparison and an overrun counter.
- Sits on the peripheral bus next to millis_timer; its millis_in is driven directly by millis_timer's dout.

---
 rtl/millis_pkg.sv | 26 ++
 rtl/millis_alarm.sv | 161 ++++++++++++++++
 tb/tb_millis_alarm.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/millis_pkg.sv
// Shared definitions for the millisecond timer peripherals.
//
// Holds the register map, the CTRL bit positions and the alarm state
// encoding. Both millis_alarm and the millis_timer bus wrapper import it,
// so the two blocks always decode the peripheral bus the same way.
package millis_pkg;

  // Register map (2-bit word address)
  localparam logic [1:0] ADDR_CMP    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_PENDING  = 2;

  // Alarm sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/millis_alarm.sv
// millis_alarm: deadline comparator for the free-running millisecond counter.
//
// Compares millis_in against a programmed deadline (CMP) using a wrap-safe
// signed difference and raises a level interrupt (irq = CTRL.pending).
// In periodic mode the deadline advances by PERIOD from the previous
// deadline (not from "now"), so the schedule never drifts; late fires are
// caught up one per cycle. Fires that land on an already-pending interrupt
// are tallied in a saturating overrun counter.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   millis_in  current millisecond count (from millis_timer dout)
//   we         single-cycle register write strobe
//   addr       register select: 0 CMP, 1 PERIOD, 2 CTRL, 3 STATUS
//   wdata      write data
//   rdata      read data, combinational from addr
//   irq        level interrupt, mirrors CTRL.pending
module millis_alarm
  import millis_pkg::*;
#(
  parameter int TIMER_WIDTH = 32,
  parameter int OVR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TIMER_WIDTH-1:0] millis_in,
  input  logic                   we,
  input  logic [1:0]             addr,
  input  logic [TIMER_WIDTH-1:0] wdata,
  output logic [TIMER_WIDTH-1:0] rdata,
  output logic                   irq
);

  // Saturating increment for the overrun tally.
  function automatic logic [OVR_WIDTH-1:0] sat_inc(input logic [OVR_WIDTH-1:0] v);
    return (&v) ? v : v + OVR_WIDTH'(1);
  endfunction

  // Deadline reached when (now - deadline) is non-negative as a signed
  // TIMER_WIDTH quantity; valid for deadlines up to half the range ahead.
  function automatic logic deadline_reached(input logic [TIMER_WIDTH-1:0] now,
                                            input logic [TIMER_WIDTH-1:0] deadline);
    logic signed [TIMER_WIDTH-1:0] diff;
    diff = $signed(now - deadline);
    return (diff >= 0);
  endfunction

  alarm_state_t           state, state_nxt;
  logic [TIMER_WIDTH-1:0] cmp, cmp_nxt;
  logic [TIMER_WIDTH-1:0] period, period_nxt;
  logic                   enable, enable_nxt;
  logic                   periodic, periodic_nxt;
  logic                   pending, pending_nxt;
  logic [OVR_WIDTH-1:0]   overrun, overrun_nxt;

  logic wr_cmp, wr_period, wr_ctrl, wr_status;
  logic match, fire, reload, clr_req;

  assign wr_cmp    = we && (addr == ADDR_CMP);
  assign wr_period = we && (addr == ADDR_PERIOD);
  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_status = we && (addr == ADDR_STATUS);

  assign match   = deadline_reached(millis_in, cmp);
  assign fire    = (state == ARMED) && enable && match;
  // A zero period would re-fire every cycle forever; treat it as one-shot.
  assign reload  = fire && periodic && (period != '0);
  assign clr_req = wr_ctrl && wdata[CTRL_PENDING];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARMED;
        ARMED:   if (fire && !reload) state_nxt = FIRED;
        FIRED:   if (wr_cmp || (wr_ctrl && wdata[CTRL_ENABLE])) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register next values
  always_comb begin
    cmp_nxt      = cmp;
    period_nxt   = period;
    enable_nxt   = enable;
    periodic_nxt = periodic;
    pending_nxt  = pending;
    overrun_nxt  = overrun;

    // Drift-free reload: advance from the old deadline. A software write
    // in the same cycle takes precedence over the reload.
    if (reload)
      cmp_nxt = cmp + period;
    if (wr_cmp)
      cmp_nxt = wdata;

    if (wr_period)
      period_nxt = wdata;

    if (wr_ctrl) begin
      enable_nxt   = wdata[CTRL_ENABLE];
      periodic_nxt = wdata[CTRL_PERIODIC];
    end

    // A fire beats a concurrent clear so no event is lost.
    if (fire)
      pending_nxt = 1'b1;
    else if (clr_req)
      pending_nxt = 1'b0;

    // A fire racing a clear counts as serviced, not as an overrun.
    if (wr_status)
      overrun_nxt = '0;
    else if (fire && pending && !clr_req)
      overrun_nxt = sat_inc(overrun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cmp      <= '0;
      period   <= '0;
      enable   <= 1'b0;
      periodic <= 1'b0;
      pending  <= 1'b0;
      overrun  <= '0;
    end else begin
      state    <= state_nxt;
      cmp      <= cmp_nxt;
      period   <= period_nxt;
      enable   <= enable_nxt;
      periodic <= periodic_nxt;
      pending  <= pending_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CMP:    rdata = cmp;
      ADDR_PERIOD: rdata = period;
      ADDR_CTRL: begin
        rdata[CTRL_ENABLE]   = enable;
        rdata[CTRL_PERIODIC] = periodic;
        rdata[CTRL_PENDING]  = pending;
      end
      ADDR_STATUS: rdata = TIMER_WIDTH'(overrun);
      default:     rdata = '0;
    endcase
  end

  assign irq = pending;

endmodule

// File: tb/tb_millis_alarm.sv
// Self-checking bench for millis_alarm: directed scenarios plus randomized
// register traffic against a behavioural reference model.
module tb_millis_alarm;
  import millis_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] millis_in;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  millis_alarm #(.TIMER_WIDTH(32), .OVR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .millis_in(millis_in), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = waiting for enable, 1 = watching deadline, 2 = spent one-shot
  logic [31:0] m_cmp, m_period;
  bit          m_en, m_per, m_pend;
  int          m_ovr;
  int          m_mode;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_cmp;
      2'd1:    return m_period;
      2'd2:    return {29'd0, m_pend, m_per, m_en};
      default: return 32'(m_ovr);
    endcase
  endfunction

  task automatic m_step(input logic r, input logic [31:0] mi, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
    logic [31:0] ahead;
    bit due, fires, again, clear;
    int nxt_mode;
    if (r) begin
      m_cmp = 0; m_period = 0; m_en = 0; m_per = 0; m_pend = 0; m_ovr = 0; m_mode = 0;
      return;
    end
    ahead = mi - m_cmp;                 // top bit set => deadline still in the future
    due   = (ahead[31] == 1'b0);
    fires = (m_mode == 1) && m_en && due;
    again = fires && m_per && (m_period != 0);
    clear = w && (a == 2) && d[2];

    if (!m_en)          nxt_mode = 0;
    else if (m_mode == 0) nxt_mode = 1;
    else if (m_mode == 1) nxt_mode = (fires && !again) ? 2 : 1;
    else                nxt_mode = (w && (a == 0 || (a == 2 && d[0]))) ? 1 : 2;

    if (w && a == 3)                 m_ovr = 0;
    else if (fires && m_pend && !clear) m_ovr = (m_ovr >= 255) ? 255 : m_ovr + 1;

    if (fires)      m_pend = 1;
    else if (clear) m_pend = 0;

    if (w && a == 0)  m_cmp = d;
    else if (again)   m_cmp = m_cmp + m_period;
    if (w && a == 1)  m_period = d;
    if (w && a == 2) begin m_en = d[0]; m_per = d[1]; end
    m_mode = nxt_mode;
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock: drive inputs, check rdata against pre-edge model, advance
  // model across the edge, then check irq after the edge.
  task automatic tick(input logic r, input logic [31:0] mi, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
    reset = r; millis_in = mi; we = w; addr = a; wdata = d;
    #1;
    chk("rdata", rdata, m_read(a));
    m_step(r, mi, w, a, d);
    @(posedge clk);
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_pend});
  endtask

  task automatic idle(input logic [31:0] mi);
    tick(1'b0, mi, 1'b0, ADDR_CTRL, 32'd0);
  endtask

  task automatic wr(input logic [31:0] mi, input logic [1:0] a, input logic [31:0] d);
    tick(1'b0, mi, 1'b1, a, d);
  endtask

  // Read a register with a constant expectation, without advancing time past the edge.
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    we = 1'b0; addr = a;
    #1;
    chk(tag, rdata, e);
  endtask

  task automatic do_reset();
    tick(1'b1, 32'd0, 1'b0, ADDR_CMP, 32'd0);
  endtask

  int          fires_q[$];
  logic        prev_irq;
  logic [31:0] mi;

  initial begin
    reset = 1'b1; millis_in = 0; we = 0; addr = 0; wdata = 0;
    m_step(1'b1, 0, 0, 0, 0);

    // Reset state
    do_reset();
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd("reset_cmp", ADDR_CMP, 0);
    rd("reset_period", ADDR_PERIOD, 0);
    rd("reset_ctrl", ADDR_CTRL, 0);
    rd("reset_status", ADDR_STATUS, 0);

    // One-shot
    wr(0, ADDR_CMP, 10);
    wr(0, ADDR_CTRL, 32'b001);
    for (int m = 0; m <= 12; m++) begin
      idle(m);
      chk("oneshot_irq", {31'd0, irq}, (m >= 10) ? 32'd1 : 32'd0);
    end
    rd("oneshot_status", ADDR_STATUS, 0);

    // Periodic with clears
    do_reset();
    wr(0, ADDR_CMP, 5);
    wr(0, ADDR_PERIOD, 3);
    wr(0, ADDR_CTRL, 32'b011);
    prev_irq = 1'b0;
    for (int m = 0; m <= 16; m++) begin
      if (prev_irq) wr(m, ADDR_CTRL, 32'b111);
      else          idle(m);
      if (irq && !prev_irq) fires_q.push_back(m);
      prev_irq = irq;
    end
    chk("periodic_nfires", fires_q.size(), 4);
    for (int i = 0; i < 4 && i < fires_q.size(); i++)
      chk("periodic_fire_at", fires_q[i], 5 + 3 * i);
    rd("periodic_cmp", ADDR_CMP, 17);

    // Wrap-around
    do_reset();
    wr(32'hFFFF_FFFC, ADDR_CMP, 2);
    wr(32'hFFFF_FFFC, ADDR_CTRL, 32'b001);
    mi = 32'hFFFF_FFFC;
    for (int i = 0; i < 8; i++) begin
      idle(mi);
      chk("wrap_irq", {31'd0, irq}, (i >= 6) ? 32'd1 : 32'd0);
      mi = mi + 1;
    end

    // Overrun saturation
    do_reset();
    wr(0, ADDR_PERIOD, 1);
    wr(0, ADDR_CTRL, 32'b011);
    for (int m = 0; m < 300; m++) idle(m);
    rd("ovr_sat", ADDR_STATUS, 255);
    wr(300, ADDR_CTRL, 32'b000);
    wr(300, ADDR_STATUS, 0);
    rd("ovr_cleared", ADDR_STATUS, 0);
    chk("ovr_pending_kept", {31'd0, irq}, 32'd1);

    // Clear/fire collision and CMP-write/reload collision
    do_reset();
    wr(0, ADDR_CMP, 5);
    wr(0, ADDR_PERIOD, 10);
    wr(0, ADDR_CTRL, 32'b011);
    for (int m = 0; m < 15; m++) idle(m);
    wr(15, ADDR_CTRL, 32'b111);
    chk("collide_irq", {31'd0, irq}, 32'd1);
    rd("collide_status", ADDR_STATUS, 0);
    rd("collide_cmp", ADDR_CMP, 25);
    for (int m = 16; m < 25; m++) idle(m);
    wr(25, ADDR_CMP, 100);
    rd("cmpwin_cmp", ADDR_CMP, 100);
    rd("cmpwin_status", ADDR_STATUS, 1);

    // Mid-operation reset
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    tick(1'b1, 26, 1'b0, ADDR_CMP, 0);
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    rd("midreset_cmp", ADDR_CMP, 0);
    rd("midreset_period", ADDR_PERIOD, 0);
    rd("midreset_ctrl", ADDR_CTRL, 0);
    rd("midreset_status", ADDR_STATUS, 0);
    idle(200);
    idle(201);
    chk("midreset_idle", {31'd0, irq}, 32'd0);

    // Randomized traffic against the model
    do_reset();
    mi = $urandom;
    for (int i = 0; i < 4000; i++) begin
      logic [1:0]  ra;
      logic [31:0] rd_v;
      if ($urandom_range(0, 99) == 0) mi = $urandom;
      else                            mi = mi + $urandom_range(0, 2);
      if ($urandom_range(0, 599) == 0) begin
        tick(1'b1, mi, 1'b0, 2'($urandom_range(0, 3)), 0);
      end else if ($urandom_range(0, 5) == 0) begin
        ra = 2'($urandom_range(0, 3));
        case (ra)
          2'd0:    rd_v = mi + $urandom_range(0, 30) - 5;
          2'd1:    rd_v = $urandom_range(0, 6);
          2'd2:    rd_v = $urandom_range(0, 7);
          default: rd_v = $urandom;
        endcase
        wr(mi, ra, rd_v);
      end else begin
        tick(1'b0, mi, 1'b0, 2'($urandom_range(0, 3)), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
